// File: rtl/proc_pkg.sv
// Shared processor constants: address/data widths, reset PC,
// prefetch depth and the opcode map used by decode.
package proc_pkg;

    localparam int PROC_AW = 9;
    localparam int PROC_DW = 32;
    localparam int FQ_DEPTH = 4;
    localparam logic [PROC_AW-1:0] PROC_RESET_PC = '0;

    localparam logic [3:0] OP_IRMOV = 4'h1;
    localparam logic [3:0] OP_ALU_RR = 4'h2;
    localparam logic [3:0] OP_ALU_RI = 4'h3;
    localparam logic [3:0] OP_MEM = 4'h4;

endpackage

// File: rtl/fq_fifo.sv
// Circular prefetch buffer of DEPTH entries with synchronous clear.
// The head is read combinationally from the storage at rd_ptr.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;
    logic             full;

    assign do_rd = rd_en && (count != '0);
    assign full = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

    // Credit logic upstream must never push into a full buffer
    // unless the head leaves in the same cycle.
    a_no_overflow : assert property (
        @(posedge clock) disable iff (reset || clear)
        !(wr_en && full && !do_rd)
    );

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: owns the PC, issues RAM reads under a credit
// limit and buffers PC-tagged words for decode.
module fetch_queue
    import proc_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW = PROC_AW,
    parameter int DW = PROC_DW,
    parameter logic [AW-1:0] RESET_PC = PROC_RESET_PC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    working,
    input  logic                    mem_busy,
    output logic                    mem_req,
    output logic [AW-1:0]           mem_addr,
    input  logic [DW-1:0]           mem_rdata,
    input  logic                    redirect_valid,
    input  logic [AW-1:0]           redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [DW-1:0]           instr,
    output logic [AW-1:0]           instr_pc,
    output logic [AW-1:0]           pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          inflight;
    logic [AW-1:0] tag;
    logic          credit_ok;
    logic          wr_en;
    logic [AW+DW-1:0] head;

    // Reserve a slot for the read in flight so the queue cannot overflow.
    assign credit_ok = (count + CW'(inflight)) < CW'(DEPTH);

    assign mem_req = ~reset & working & ~mem_busy
                   & ~redirect_valid & credit_ok;
    assign mem_addr = pc;

    // A redirect in the response cycle turns that response stale.
    assign wr_en = inflight & ~redirect_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            tag <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                pc <= pc + 1'b1;
                tag <= pc;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (redirect_valid),
        .wr_en   (wr_en),
        .wr_data ({tag, mem_rdata}),
        .rd_en   (instr_valid & instr_ready),
        .rd_data (head),
        .count   (count)
    );

    assign instr_valid = (count != '0);
    assign instr = head[DW-1:0];
    assign instr_pc = head[AW+DW-1:DW];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected
// (pc, word) pairs; a negedge monitor checks each accepted instruction.
module tb_fetch_queue;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          working = 1'b0;
    logic          mem_busy = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] pc;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [512];
    logic [AW-1:0] sb_pc [$];
    logic [DW-1:0] sb_word [$];

    fetch_queue #(
        .DEPTH (DEPTH),
        .AW (AW),
        .DW (DW),
        .RESET_PC ('0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .working        (working),
        .mem_busy       (mem_busy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc             (pc),
        .count          (count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_rdata <= ram[mem_addr];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_range(input int first, input int last);
        int p;
        p = first;
        forever begin
            sb_pc.push_back(AW'(p));
            sb_word.push_back(ram[p]);
            if (p == last) break;
            p = (p + 1) % 512;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Fetch until address `last` is issued, then stop and drain.
    task automatic run_to(input int last);
        bit found;
        found = 0;
        working = 1'b1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clock);
            if (mem_req && mem_addr == AW'(last)) found = 1;
        end
        chk("run_to_reach", 32'(found), 32'd1);
        step();
        working = 1'b0;
        repeat (6) step();
    endtask

    always @(negedge clock) begin
        if (!reset && instr_valid && instr_ready) begin
            if (sb_pc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h word %h",
                         instr_pc, instr);
            end else begin
                chk("instr_pc", 32'(instr_pc), 32'(sb_pc.pop_front()));
                chk("instr", instr, sb_word.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n_iss;
        bit found;
        for (int i = 0; i < 512; i++) ram[i] = 32'hC000_0000 | 32'(i);
        ram[0] = 32'h1000_0005;
        ram[1] = 32'h2001_0000;
        ram[2] = 32'h2101_0000;
        ram[3] = 32'h3012_0000;
        ram[9'h41] = 32'h0;

        #1 reset = 1'b1;
        working = 1'b1;
        instr_ready = 1'b1;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);

        // Streaming from reset.
        push_range(0, 3);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("a_req", 32'(mem_req), 32'd1);
            chk("a_addr", 32'(mem_addr), 32'(k));
            chk("a_valid", 32'(instr_valid), 32'(k >= 2));
            chk("a_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        step();
        working = 1'b0;
        repeat (6) step();

        // Decode stall: credit limits issues to DEPTH.
        push_range(4, 9);
        instr_ready = 1'b0;
        working = 1'b1;
        n_iss = 0;
        repeat (10) begin
            @(negedge clock);
            if (mem_req) n_iss++;
        end
        chk("b_issues", 32'(n_iss), 32'd4);
        chk("b_count", 32'(count), 32'd4);
        chk("b_req", 32'(mem_req), 32'd0);
        chk("b_head_pc", 32'(instr_pc), 32'd4);
        chk("b_head", instr, ram[4]);
        step();
        instr_ready = 1'b1;
        run_to(9);

        // RAM port busy right after an issue.
        push_range(10, 11);
        working = 1'b1;
        @(negedge clock);
        chk("c_req", 32'(mem_req), 32'd1);
        chk("c_addr", 32'(mem_addr), 32'd10);
        step();
        mem_busy = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("c_busy_req", 32'(mem_req), 32'd0);
            chk("c_busy_pc", 32'(pc), 32'd11);
            step();
        end
        mem_busy = 1'b0;
        @(negedge clock);
        chk("c_resume_addr", 32'(mem_req ? mem_addr : 9'h1aa), 32'd11);
        step();
        working = 1'b0;
        repeat (6) step();

        // Redirect one cycle after an issue.
        push_range(9'h40, 9'h43);
        working = 1'b1;
        @(negedge clock);
        chk("d_addr12", 32'(mem_req ? mem_addr : 9'h1aa), 32'd12);
        step();
        @(negedge clock);
        chk("d_addr13", 32'(mem_req ? mem_addr : 9'h1aa), 32'd13);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 9'h40;
        instr_ready = 1'b0;
        @(negedge clock);
        chk("d_redir_req", 32'(mem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clock);
        chk("d_flush_count", 32'(count), 32'd0);
        chk("d_new_addr", 32'(mem_req ? mem_addr : 9'h1aa), 32'h40);
        run_to(9'h43);

        // PC wrap at the top of the address space.
        push_range(9'h1fe, 1);
        redirect_valid = 1'b1;
        redirect_pc = 9'h1fe;
        step();
        redirect_valid = 1'b0;
        run_to(1);
        chk("e_pc_wrap", 32'(pc), 32'd2);

        // Async reset with a full-ish queue and a read in flight.
        instr_ready = 1'b0;
        working = 1'b1;
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 9'd5) found = 1;
        end
        chk("f_reach5", 32'(found), 32'd1);
        @(posedge clock);
        #1;
        chk("f_pre_count", 32'(count), 32'd3);
        #1 reset = 1'b1;
        working = 1'b0;
        #1;
        chk("f_rst_count", 32'(count), 32'd0);
        chk("f_rst_valid", 32'(instr_valid), 32'd0);
        chk("f_rst_req", 32'(mem_req), 32'd0);
        chk("f_rst_instr", instr, 32'd0);
        chk("f_rst_pc", 32'(pc), 32'd0);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("f_stale_count", 32'(count), 32'd0);
        push_range(0, 2);
        instr_ready = 1'b1;
        working = 1'b1;
        #1;
        chk("f_restart_addr", 32'(mem_req ? mem_addr : 9'h1aa), 32'd0);
        run_to(2);

        chk("sb_empty", 32'(sb_pc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
